bit_serial_adder: RTL and testbench

Bit-serial add/subtract unit for two WIDTH-bit operands, one bit per clock, LSB first.
- A load/shift datapath and FSM feed the single carry flip-flop; sum bits shift into a result register.
- Serves as the operand/sequencing stage around the carry storage element in the sequential-arithmetic lab set.
- Handshake is start/busy/done; result, carry-out and signed overflow are held until the next operation.

---
 rtl/bit_serial_adder.sv | 90 +++++++++
 tb/tb_bit_serial_adder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_adder.sv
// Bit-serial add/subtract over two WIDTH-bit operands, LSB first, one bit per clock.
// A single carry flip-flop is shared across bits; start/busy/done handshake.
module bit_serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, carry_d, s_d;
  logic             cout_q, ovf_q, busy_q, done_q;
  logic             last_bit;

  always_comb begin
    s_d      = a_q[0] ^ b_q[0] ^ carry_q;
    carry_d  = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    sum_d    = {s_d, sum_q[WIDTH-1:1]};
    last_bit = (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          sum_q   <= sum_d;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CW'(1);
          if (last_bit) begin
            // carry_q here is the carry into the MSB, carry_d the carry out of it
            cout_q  <= carry_d;
            ovf_q   <= carry_q ^ carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub;
            cnt_q   <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder (WIDTH=8): vector table, random ops
// against an arithmetic reference model, and hand-written multi-cycle sequences.
module tb_bit_serial_adder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset, start, sub;
  logic [W-1:0] a, b;
  logic [W-1:0] sum;
  logic         cout, overflow, busy, done;

  int checks   = 0;
  int failures = 0;

  logic last_cout = 1'b0;
  logic last_ovf  = 1'b0;

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b),
    .sum(sum), .cout(cout), .overflow(overflow), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model from plain signed/unsigned arithmetic.
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                       output logic [W-1:0] r, output logic co, output logic ov);
    int sx, sy, res;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (s) begin
      r   = x - y;
      co  = (x >= y);
      res = sx - sy;
    end else begin
      r   = x + y;
      co  = (int'(x) + int'(y)) > 255;
      res = sx + sy;
    end
    ov = (res > 127) || (res < -128);
  endtask

  // Full operation from IDLE: start edge, latency, busy span, result, done pulse width.
  task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic s, input logic [W-1:0] es, input logic ec, input logic eo);
    int n, busy_cnt;
    a = x; b = y; sub = s; start = 1'b1;
    tick();
    start = 1'b0;
    check({name, ".load_sum"}, sum, 0);
    check({name, ".hold_cout"}, cout, last_cout);
    check({name, ".hold_ovf"}, overflow, last_ovf);
    n = 999;
    busy_cnt = busy ? 1 : 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done) begin n = i; break; end
      if (busy) busy_cnt++;
    end
    check({name, ".latency"}, n, W);
    check({name, ".busy_cycles"}, busy_cnt, W);
    check({name, ".busy_in_done"}, busy, 0);
    check({name, ".sum"}, sum, es);
    check({name, ".cout"}, cout, ec);
    check({name, ".ovf"}, overflow, eo);
    last_cout = ec;
    last_ovf  = eo;
    tick();
    check({name, ".done_pulse"}, done, 0);
    check({name, ".sum_held"}, sum, es);
  endtask

  vec_t vecs[8];

  initial begin
    logic [W-1:0] rs;
    logic rc, ro;
    int n, pulses;
    logic [W-1:0] first_sum;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[6] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[7] = '{8'h80, 8'h80, 1'b1, 8'h00, 1'b1, 1'b0};

    reset = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    tick(); tick();
    reset = 1'b0;
    check("reset.sum", sum, 0);
    check("reset.cout", cout, 0);
    check("reset.ovf", overflow, 0);
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub,
             vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);

    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] x, y;
      logic s;
      x = W'($urandom);
      y = W'($urandom);
      s = 1'($urandom);
      model(x, y, s, rs, rc, ro);
      run_op($sformatf("rnd%0d", i), x, y, s, rs, rc, ro);
    end

    // start pulsed mid-RUN must be ignored
    a = 8'h10; b = 8'h20; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    pulses = 0; n = 999; first_sum = '0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) begin a = 8'hFF; b = 8'hFF; start = 1'b1; end
      if (i == 4) start = 1'b0;
      tick();
      if (done) begin
        pulses++;
        if (n == 999) begin n = i; first_sum = sum; end
      end
    end
    check("ignore.latency", n, W);
    check("ignore.sum", first_sum, 8'h30);
    check("ignore.pulses", pulses, 1);
    check("ignore.busy", busy, 0);
    last_cout = 1'b0; last_ovf = 1'b0;

    // back-to-back: start held in the DONE cycle
    a = 8'h10; b = 8'h20; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    n = 999;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done) begin n = i; break; end
    end
    check("b2b.first_latency", n, W);
    check("b2b.first_sum", sum, 8'h30);
    a = 8'h01; b = 8'h02; start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b.busy_no_idle", busy, 1);
    check("b2b.done_low", done, 0);
    check("b2b.load_sum", sum, 0);
    n = 999;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done) begin n = i; break; end
    end
    check("b2b.second_latency", n, W);
    check("b2b.second_sum", sum, 8'h03);
    check("b2b.second_cout", cout, 0);
    tick();

    // reset in the middle of RUN abandons the operation
    a = 8'hFF; b = 8'h01; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset.sum", sum, 0);
    check("midreset.cout", cout, 0);
    check("midreset.ovf", overflow, 0);
    check("midreset.busy", busy, 0);
    check("midreset.done", done, 0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) pulses++;
    end
    check("midreset.no_activity", pulses, 0);
    last_cout = 1'b0; last_ovf = 1'b0;
    run_op("after_reset", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
